// File: rtl/eth_pkg.sv
// Shared Ethernet TX constants and types: CRC-32 seeds, residue and the FCS-append FSM states.
// Purely declarative, so there is no latency and no backpressure.
package eth_pkg;

    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
    localparam int          ETH_MIN_FRAME = 60;

    typedef enum logic [1:0] {
        TX_DATA,
        TX_PAD,
        TX_FCS
    } tx_fcs_state_t;

endpackage

// File: rtl/eth_tx_fcs_append_if.sv
// Byte stream carrying data/valid/last forward and ready backward.
// The master holds data/valid/last stable while ready is low.
interface eth_tx_fcs_append_if;

    logic [7:0] data;
    logic       valid;
    logic       last;
    logic       ready;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/crc32_8bit.sv
// Next-state CRC-32 (reflected 0xEDB88320) for one byte, LSB first.
// Combinational with zero latency; it has no handshake.
module crc32_8bit
    import eth_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] w_crc;

    always_comb begin
        w_crc = i_crc;
        for (int b = 0; b < 8; b++) begin
            w_crc = (w_crc >> 1) ^ (((w_crc[0] ^ i_data[b]) == 1'b1) ? CRC32_POLY : 32'h0);
        end
        o_crc = w_crc;
    end

endmodule

// File: rtl/eth_tx_fcs_append.sv
// Pads short frames with zeros to MIN_FRAME, then appends the 4-byte FCS. The latency is 1 clk.
// in_ready follows out_ready combinationally and is low during PAD/FCS. The output holds while stalled.
module eth_tx_fcs_append
    import eth_pkg::*;
#(
    parameter int MIN_FRAME = ETH_MIN_FRAME,
    parameter int CNT_W     = 11
) (
    input  logic                   clk,
    input  logic                   reset_n,
    eth_tx_fcs_append_if.slave     in_if,
    eth_tx_fcs_append_if.master    out_if
);

    localparam logic [CNT_W:0] MIN_W = (CNT_W+1)'(MIN_FRAME);

    tx_fcs_state_t    r_state, w_state_nxt;
    logic [31:0]      r_crc, w_crc_nxt, w_crc_upd;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_sat;
    logic [CNT_W:0]   w_cnt_inc;
    logic [1:0]       r_fcs_idx, w_fcs_idx_nxt;
    logic [7:0]       r_out_data, w_out_data_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic             r_out_last, w_out_last_nxt;
    logic [7:0]       w_crc_in, w_fcs_byte;
    logic             w_adv, w_xfer;

    assign w_adv       = !r_out_valid || out_if.ready;
    assign in_if.ready = reset_n && w_adv && (r_state == TX_DATA);
    assign w_xfer      = in_if.valid && in_if.ready;

    // The counter stops at MIN_FRAME. Long frames therefore never wrap back into padding.
    assign w_cnt_inc  = {1'b0, r_cnt} + 1'b1;
    assign w_cnt_sat  = ({1'b0, r_cnt} >= MIN_W) ? r_cnt : w_cnt_inc[CNT_W-1:0];
    assign w_crc_in   = (r_state == TX_DATA) ? in_if.data : 8'h00;
    assign w_fcs_byte = ~r_crc[{r_fcs_idx, 3'b000} +: 8];

    crc32_8bit u_crc (
        .i_crc  (r_crc),
        .i_data (w_crc_in),
        .o_crc  (w_crc_upd)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= TX_DATA;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            TX_DATA: begin
                if (w_xfer && in_if.last) begin
                    w_state_nxt = (w_cnt_inc < MIN_W) ? TX_PAD : TX_FCS;
                end
            end
            TX_PAD: begin
                if (w_adv && (w_cnt_inc >= MIN_W)) begin
                    w_state_nxt = TX_FCS;
                end
            end
            TX_FCS: begin
                if (w_adv && (r_fcs_idx == 2'd3)) begin
                    w_state_nxt = TX_DATA;
                end
            end
            default: w_state_nxt = TX_DATA;
        endcase
    end

    always_comb begin
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        w_out_last_nxt  = r_out_last;
        w_crc_nxt       = r_crc;
        w_cnt_nxt       = r_cnt;
        w_fcs_idx_nxt   = r_fcs_idx;
        case (r_state)
            TX_DATA: begin
                if (w_xfer) begin
                    w_out_data_nxt  = in_if.data;
                    w_out_valid_nxt = 1'b1;
                    w_out_last_nxt  = 1'b0;
                    w_crc_nxt       = w_crc_upd;
                    w_cnt_nxt       = w_cnt_sat;
                end else if (w_adv) begin
                    w_out_valid_nxt = 1'b0;
                    w_out_last_nxt  = 1'b0;
                end
            end
            TX_PAD: begin
                if (w_adv) begin
                    w_out_data_nxt  = 8'h00;
                    w_out_valid_nxt = 1'b1;
                    w_out_last_nxt  = 1'b0;
                    w_crc_nxt       = w_crc_upd;
                    w_cnt_nxt       = w_cnt_sat;
                end
            end
            TX_FCS: begin
                if (w_adv) begin
                    w_out_data_nxt  = w_fcs_byte;
                    w_out_valid_nxt = 1'b1;
                    w_out_last_nxt  = 1'b0;
                    w_fcs_idx_nxt   = r_fcs_idx + 2'd1;
                    // The last FCS byte re-arms the CRC and the counters, so the next frame can start one clk later.
                    if (r_fcs_idx == 2'd3) begin
                        w_out_last_nxt = 1'b1;
                        w_crc_nxt      = CRC32_INIT;
                        w_cnt_nxt      = '0;
                        w_fcs_idx_nxt  = 2'd0;
                    end
                end
            end
            default: begin
                w_out_valid_nxt = 1'b0;
                w_out_last_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_crc       <= CRC32_INIT;
            r_cnt       <= '0;
            r_fcs_idx   <= 2'd0;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_crc       <= w_crc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_fcs_idx   <= w_fcs_idx_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_last  <= w_out_last_nxt;
        end
    end

    assign out_if.data  = r_out_data;
    assign out_if.valid = r_out_valid;
    assign out_if.last  = r_out_last;

endmodule

// File: tb/tb_eth_tx_fcs_append.sv
// Directed bench for eth_tx_fcs_append. The u_dut instance uses MIN_FRAME=60 and the u_dut0 instance uses MIN_FRAME=0.
// Both instances share one input stream and one out_ready.
`timescale 1ns/1ps
module tb_eth_tx_fcs_append;
    import eth_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;
    bit         rnd_mode = 1'b0;
    logic       rdy_fix = 1'b1;

    always #5 clk = ~clk;

    eth_tx_fcs_append_if in_if ();
    eth_tx_fcs_append_if out_if ();
    eth_tx_fcs_append_if in0_if ();
    eth_tx_fcs_append_if out0_if ();

    assign in_if.data   = in_data;
    assign in_if.valid  = in_valid;
    assign in_if.last   = in_last;
    assign in0_if.data  = in_data;
    assign in0_if.valid = in_valid;
    assign in0_if.last  = in_last;
    assign out_if.ready  = out_ready;
    assign out0_if.ready = out_ready;

    eth_tx_fcs_append #(.MIN_FRAME(60), .CNT_W(11)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_if(in_if), .out_if(out_if));
    eth_tx_fcs_append #(.MIN_FRAME(0), .CNT_W(11)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .in_if(in0_if), .out_if(out0_if));

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] q_data[$];
    bit         q_last[$];
    logic [7:0] q0_data[$];
    bit         q0_last[$];
    int   stall_err, bubble_cnt, last_vis_cnt, in_stall;
    bit   last_seen;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic prev_last;

    logic [7:0] frm[0:255];
    int         gap_after[0:255];

    always @(posedge clk) begin
        #1;
        out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : rdy_fix;
    end

    always @(negedge clk) begin
        if (out_if.valid && out_ready) begin
            q_data.push_back(out_if.data);
            q_last.push_back(out_if.last);
            if (out_if.last) last_seen = 1'b1;
        end
        if (!out_if.valid && q_data.size() > 0 && !last_seen) bubble_cnt++;
        if (out_if.valid && out_if.last) last_vis_cnt++;
        if (prev_stall && (out_if.data !== prev_data || out_if.last !== prev_last || out_if.valid !== 1'b1))
            stall_err++;
        prev_stall = out_if.valid && !out_ready;
        prev_data  = out_if.data;
        prev_last  = out_if.last;
        if (out0_if.valid && out_ready) begin
            q0_data.push_back(out0_if.data);
            q0_last.push_back(out0_if.last);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at 2ms, required finish");
        $fatal(1);
    end

    function automatic logic [31:0] crc_upd(logic [31:0] c, logic [7:0] d);
        logic [31:0] r = c;
        for (int b = 0; b < 8; b++) begin
            if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB8_8320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Expected FCS word for frm[base..base+len-1] padded with zeros to padto bytes.
    function automatic logic [31:0] frm_fcs(int base, int len, int padto);
        logic [31:0] c = 32'hFFFF_FFFF;
        int n = (len > padto) ? len : padto;
        for (int k = 0; k < n; k++) c = crc_upd(c, (k < len) ? frm[base + k] : 8'h00);
        return ~c;
    endfunction

    function automatic logic [31:0] q_residue(int base, int n);
        logic [31:0] c = 32'hFFFF_FFFF;
        for (int k = 0; k < n; k++) c = crc_upd(c, q_data[base + k]);
        return c;
    endfunction

    function automatic logic [31:0] q_word(int base);
        return {q_data[base + 3], q_data[base + 2], q_data[base + 1], q_data[base]};
    endfunction

    function automatic int q_last_cnt();
        int s = 0;
        foreach (q_last[k]) s += int'(q_last[k]);
        return s;
    endfunction

    task automatic clear_mon();
        q_data.delete(); q_last.delete(); q0_data.delete(); q0_last.delete();
        stall_err = 0; bubble_cnt = 0; last_vis_cnt = 0; last_seen = 1'b0;
        prev_stall = 1'b0; in_stall = 0;
    endtask

    task automatic send_frame(input int base, input int len, input bit with_last);
        for (int i = 0; i < len; i++) begin
            int to = 0;
            in_data  = frm[base + i];
            in_valid = 1'b1;
            in_last  = with_last && (i == len - 1);
            @(negedge clk);
            while (!in_if.ready && to < 2000) begin
                in_stall++; to++;
                @(negedge clk);
            end
            if (to >= 2000) begin
                n_checks++;
                $display("FAIL send_timeout byte %0d: in_ready=0 for 2000 clks, required 1", i);
                in_valid = 1'b0; in_last = 1'b0;
                return;
            end
            @(posedge clk); #1;
            in_valid = 1'b0; in_last = 1'b0;
            repeat (gap_after[base + i]) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_out(input int n, input string nm);
        int to = 0;
        while (q_data.size() < n && to < 3000) begin @(negedge clk); to++; end
        repeat (8) @(posedge clk);
        #1;
        n_checks++;
        if (q_data.size() != n) $display("FAIL %s_len: got %0d bytes, required %0d", nm, q_data.size(), n);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b1; in_data = 8'h5A; rdy_fix = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (out_if.valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", out_if.valid); else n_pass++;
        n_checks++; if (out_if.last !== 1'b0) $display("FAIL rst_last: got %b, required 0", out_if.last); else n_pass++;
        n_checks++; if (out_if.data !== 8'h00) $display("FAIL rst_data: got %h, required 00", out_if.data); else n_pass++;
        n_checks++; if (in_if.ready !== 1'b0) $display("FAIL rst_in_ready: got %b, required 0", in_if.ready); else n_pass++;
        @(posedge clk); #1;
        reset_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (in_if.ready !== 1'b1) $display("FAIL rst_release_ready: got %b, required 1", in_if.ready); else n_pass++;
        n_checks++; if (out_if.valid !== 1'b0) $display("FAIL rst_release_valid: got %b, required 0", out_if.valid); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_crc_check();
        logic [7:0] exp1 [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                                  8'h26, 8'h39, 8'hF4, 8'hCB};
        clear_mon();
        for (int i = 0; i < 9; i++) frm[i] = 8'(8'h31 + i);
        send_frame(0, 9, 1'b1);
        wait_out(64, "crc_main");
        n_checks++;
        if (q0_data.size() != 13) $display("FAIL crc_len0: got %0d bytes, required 13", q0_data.size());
        else begin
            n_pass++;
            for (int j = 0; j < 13; j++) begin
                n_checks++;
                if (q0_data[j] !== exp1[j]) $display("FAIL crc_byte%0d: got %h, required %h", j, q0_data[j], exp1[j]);
                else n_pass++;
                n_checks++;
                if (q0_last[j] !== (j == 12)) $display("FAIL crc_last%0d: got %b, required %b", j, q0_last[j], (j == 12));
                else n_pass++;
            end
        end
    endtask

    task automatic test_min_pad();
        int nz = 0;
        logic [31:0] fcs;
        clear_mon();
        frm[0] = 8'hAA;
        fcs = frm_fcs(0, 1, 60);
        send_frame(0, 1, 1'b1);
        @(negedge clk);
        n_checks++; if (in_if.ready !== 1'b0) $display("FAIL pad_in_ready: got %b, required 0", in_if.ready); else n_pass++;
        wait_out(64, "pad");
        if (q_data.size() == 64) begin
            for (int j = 1; j < 60; j++) if (q_data[j] !== 8'h00) nz++;
            n_checks++; if (q_data[0] !== 8'hAA) $display("FAIL pad_first: got %h, required aa", q_data[0]); else n_pass++;
            n_checks++; if (nz != 0) $display("FAIL pad_zeros: got %0d nonzero pad bytes, required 0", nz); else n_pass++;
            n_checks++; if (q_word(60) !== fcs) $display("FAIL pad_fcs: got %h, required %h", q_word(60), fcs); else n_pass++;
            n_checks++; if (q_residue(0, 64) !== CRC32_RESIDUE) $display("FAIL pad_residue: got %h, required %h", q_residue(0, 64), CRC32_RESIDUE); else n_pass++;
            n_checks++; if (q_last[63] !== 1'b1 || q_last_cnt() != 1) $display("FAIL pad_last: got last63=%b count=%0d, required 1/1", q_last[63], q_last_cnt()); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        logic [31:0] fa, fb;
        clear_mon();
        for (int i = 0; i < 60; i++) frm[i] = 8'(i * 7 + 3);
        for (int i = 0; i < 61; i++) frm[100 + i] = 8'(i * 11 + 200);
        fa = frm_fcs(0, 60, 60);
        fb = frm_fcs(100, 61, 60);
        send_frame(0, 60, 1'b1);
        send_frame(100, 61, 1'b1);
        n_checks++; if (in_stall != 4) $display("FAIL b2b_in_stall: got %0d stalled clks, required 4", in_stall); else n_pass++;
        wait_out(129, "b2b");
        if (q_data.size() == 129) begin
            for (int j = 0; j < 60; j++) if (q_data[j] !== frm[j]) bad++;
            for (int j = 0; j < 61; j++) if (q_data[64 + j] !== frm[100 + j]) bad++;
            n_checks++; if (bad != 0) $display("FAIL b2b_content: got %0d wrong bytes, required 0", bad); else n_pass++;
            n_checks++; if (q_word(60) !== fa) $display("FAIL b2b_fcs_a: got %h, required %h", q_word(60), fa); else n_pass++;
            n_checks++; if (q_word(125) !== fb) $display("FAIL b2b_fcs_b: got %h, required %h", q_word(125), fb); else n_pass++;
            n_checks++; if (q_residue(0, 64) !== CRC32_RESIDUE) $display("FAIL b2b_res_a: got %h, required %h", q_residue(0, 64), CRC32_RESIDUE); else n_pass++;
            n_checks++; if (q_residue(64, 65) !== CRC32_RESIDUE) $display("FAIL b2b_res_b: got %h, required %h", q_residue(64, 65), CRC32_RESIDUE); else n_pass++;
            n_checks++;
            if (q_last[63] !== 1'b1 || q_last[128] !== 1'b1 || q_last_cnt() != 2)
                $display("FAIL b2b_last: got last63=%b last128=%b count=%0d, required 1/1/2", q_last[63], q_last[128], q_last_cnt());
            else n_pass++;
        end
    endtask

    task automatic test_random_ready();
        logic [7:0] ref_q[$];
        int bad = 0;
        logic [31:0] fcs;
        for (int i = 0; i < 100; i++) frm[i] = 8'(i * 13 + 5);
        fcs = frm_fcs(0, 100, 60);
        clear_mon();
        send_frame(0, 100, 1'b1);
        wait_out(104, "rdy_ref");
        ref_q = q_data;
        clear_mon();
        rnd_mode = 1'b1;
        send_frame(0, 100, 1'b1);
        wait_out(104, "rdy_rand");
        rnd_mode = 1'b0;
        @(posedge clk); #1;
        if (q_data.size() == 104 && ref_q.size() == 104) begin
            for (int j = 0; j < 104; j++) if (q_data[j] !== ref_q[j]) bad++;
            n_checks++; if (bad != 0) $display("FAIL rdy_order: got %0d differing bytes, required 0", bad); else n_pass++;
            n_checks++; if (q_word(100) !== fcs) $display("FAIL rdy_fcs: got %h, required %h", q_word(100), fcs); else n_pass++;
            n_checks++; if (q_last_cnt() != 1 || q_last[103] !== 1'b1) $display("FAIL rdy_last: got count=%0d, required 1 on byte 103", q_last_cnt()); else n_pass++;
        end
        n_checks++; if (stall_err != 0) $display("FAIL rdy_stable: got %0d stall changes, required 0", stall_err); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        logic [31:0] fcs;
        clear_mon();
        for (int i = 0; i < 20; i++) frm[i] = 8'(8'hC0 + i);
        send_frame(0, 20, 1'b0);
        reset_n = 1'b0; rdy_fix = 1'b0;
        @(negedge clk);
        n_checks++; if (in_if.ready !== 1'b0) $display("FAIL mrst_in_ready: got %b, required 0", in_if.ready); else n_pass++;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (out_if.valid !== 1'b0) $display("FAIL mrst_valid: got %b, required 0", out_if.valid); else n_pass++;
        rdy_fix = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (last_vis_cnt != 0) $display("FAIL mrst_no_last: got %0d out_last cycles, required 0", last_vis_cnt); else n_pass++;
        clear_mon();
        for (int i = 0; i < 25; i++) frm[i] = 8'(i) ^ 8'h5C;
        fcs = frm_fcs(0, 25, 60);
        send_frame(0, 25, 1'b1);
        wait_out(64, "mrst_next");
        if (q_data.size() == 64) begin
            n_checks++; if (q_word(60) !== fcs) $display("FAIL mrst_fcs: got %h, required %h", q_word(60), fcs); else n_pass++;
            n_checks++; if (q_data[0] !== 8'h5C) $display("FAIL mrst_first: got %h, required 5c", q_data[0]); else n_pass++;
        end
    endtask

    task automatic test_gaps();
        int bad = 0;
        logic [31:0] fcs;
        clear_mon();
        for (int i = 0; i < 30; i++) frm[i] = 8'(8'h40 + i * 3);
        gap_after[3] = 1; gap_after[10] = 2; gap_after[17] = 3; gap_after[25] = 1;
        fcs = frm_fcs(0, 30, 60);
        send_frame(0, 30, 1'b1);
        wait_out(64, "gap");
        for (int i = 0; i < 256; i++) gap_after[i] = 0;
        n_checks++; if (bubble_cnt != 7) $display("FAIL gap_bubbles: got %0d, required 7", bubble_cnt); else n_pass++;
        if (q_data.size() == 64) begin
            for (int j = 0; j < 30; j++) if (q_data[j] !== frm[j]) bad++;
            n_checks++; if (bad != 0) $display("FAIL gap_content: got %0d wrong bytes, required 0", bad); else n_pass++;
            n_checks++; if (q_word(60) !== fcs) $display("FAIL gap_fcs: got %h, required %h", q_word(60), fcs); else n_pass++;
            n_checks++; if (q_residue(0, 64) !== CRC32_RESIDUE) $display("FAIL gap_residue: got %h, required %h", q_residue(0, 64), CRC32_RESIDUE); else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            gap_after[i] = 0;
            frm[i] = 8'h00;
        end
        clear_mon();
        test_reset();
        test_crc_check();
        test_min_pad();
        test_back_to_back();
        test_random_ready();
        test_reset_midframe();
        test_gaps();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
